// File: rtl/mtsp_alu_result_collector.sv
// Dual-phase ALU result collector: FIFO of {tag, dword} drained by a valid/ready write-back port.
// Optional same-cycle bypass when empty: define MTSP_ALU_COLLECT_BYPASS_EN.
module mtsp_alu_result_collector #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_MARGIN = 6,
   parameter int unsigned AW        = 6
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [1:0]              PHASE_EN,
   input  logic [31:0]             DIN0,
   input  logic [31:0]             DIN1,
   input  logic [AW-1:0]           TAG0,
   input  logic [AW-1:0]           TAG1,
   output logic                    WB_VALID,
   input  logic                    WB_READY,
   output logic [31:0]             WB_DATA,
   output logic [AW-1:0]           WB_ADDR,
   output logic                    ALMOST_FULL,
   output logic                    OVERFLOW,
   output logic [$clog2(DEPTH):0]  COUNT
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = AW + 32;

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d, free_slots;
   logic          overflow_q, overflow_d, almost_full_q, almost_full_d;
   logic          fifo_valid, pop, bypass, bypass_taken, push0, push1, dropped;
   logic [EW-1:0] ent0, ent1, head;

   assign ent0 = {TAG0, DIN0};
   assign ent1 = {TAG1, DIN1};
   assign head = mem_q[rd_ptr_q];

   always_comb begin
      fifo_valid = (count_q != '0);
      pop        = fifo_valid && WB_READY;
      bypass     = 1'b0;
`ifdef MTSP_ALU_COLLECT_BYPASS_EN
      bypass     = !RST && !fifo_valid && (PHASE_EN == 2'b01 || PHASE_EN == 2'b10);
`endif
      // A bypassed result accepted by the register file never enters the FIFO
      bypass_taken = bypass && WB_READY;
      free_slots   = CW'(DEPTH) - count_q + CW'(pop);
      push0        = 1'b0;
      push1        = 1'b0;
      if (!RST && !bypass_taken) begin
         push0 = PHASE_EN[0] && (free_slots != '0);
         push1 = PHASE_EN[1] && (free_slots > CW'(PHASE_EN[0]));
      end
      dropped = !RST && !bypass_taken &&
                ((PHASE_EN[0] && !push0) || (PHASE_EN[1] && !push1));

      wr_ptr_d      = wr_ptr_q + PW'(push0) + PW'(push1);
      rd_ptr_d      = rd_ptr_q + PW'(pop);
      count_d       = count_q + CW'(push0) + CW'(push1) - CW'(pop);
      overflow_d    = overflow_q | dropped;
      almost_full_d = (CW'(DEPTH) - count_d) < CW'(AF_MARGIN);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         almost_full_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         almost_full_q <= almost_full_d;
      end
   end

   // Storage needs no reset: outputs are gated by occupancy
   always_ff @(posedge CLK) begin
      if (push0) mem_q[wr_ptr_q] <= ent0;
      if (push1) mem_q[wr_ptr_q + PW'(push0)] <= ent1;
   end

   always_comb begin
      WB_VALID = fifo_valid;
      WB_DATA  = '0;
      WB_ADDR  = '0;
      if (fifo_valid) begin
         WB_DATA = head[31:0];
         WB_ADDR = head[EW-1:32];
      end else if (bypass) begin
         WB_VALID = 1'b1;
         WB_DATA  = PHASE_EN[0] ? DIN0 : DIN1;
         WB_ADDR  = PHASE_EN[0] ? TAG0 : TAG1;
      end
   end

   assign COUNT       = count_q;
   assign OVERFLOW    = overflow_q;
   assign ALMOST_FULL = almost_full_q;

endmodule

// File: tb/tb_mtsp_alu_result_collector.sv
// Self-checking bench for mtsp_alu_result_collector: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_mtsp_alu_result_collector;
   localparam int unsigned DEPTH     = 8;
   localparam int unsigned AF_MARGIN = 6;
   localparam int unsigned AW        = 6;
   localparam int unsigned CW        = $clog2(DEPTH) + 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [1:0]    PHASE_EN = '0;
   logic [31:0]   DIN0 = '0, DIN1 = '0;
   logic [AW-1:0] TAG0 = '0, TAG1 = '0;
   logic          WB_VALID, WB_READY = 1'b0;
   logic [31:0]   WB_DATA;
   logic [AW-1:0] WB_ADDR;
   logic          ALMOST_FULL, OVERFLOW;
   logic [CW-1:0] COUNT;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: ordered list of stored {tag, data} plus sticky flags
   logic [AW+31:0] q[$];
   bit m_ov = 0;
   bit m_af = 0;

   mtsp_alu_result_collector #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .AW(AW)) dut (
      .CLK(CLK), .RST(RST), .PHASE_EN(PHASE_EN), .DIN0(DIN0), .DIN1(DIN1),
      .TAG0(TAG0), .TAG1(TAG1), .WB_VALID(WB_VALID), .WB_READY(WB_READY),
      .WB_DATA(WB_DATA), .WB_ADDR(WB_ADDR), .ALMOST_FULL(ALMOST_FULL),
      .OVERFLOW(OVERFLOW), .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs against the model, then advance the model
   task automatic cycle(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [AW-1:0] t0, input logic [AW-1:0] t1, input logic rdy);
      bit byp, pop;
      int free;
      logic exp_v;
      logic [AW+31:0] exp_h;
      @(negedge CLK);
      PHASE_EN = en; DIN0 = d0; DIN1 = d1; TAG0 = t0; TAG1 = t1; WB_READY = rdy;
      #1;
      byp = 0;
`ifdef MTSP_ALU_COLLECT_BYPASS_EN
      byp = (q.size() == 0) && (en == 2'b01 || en == 2'b10);
`endif
      exp_v = (q.size() != 0);
      exp_h = '0;
      if (q.size() != 0) exp_h = q[0];
      else if (byp) begin
         exp_v = 1'b1;
         exp_h = en[0] ? {t0, d0} : {t1, d1};
      end
      check_eq("wb_valid", WB_VALID, exp_v);
      check_eq("wb_data", WB_DATA, exp_h[31:0]);
      check_eq("wb_addr", WB_ADDR, exp_h[AW+31:32]);
      check_eq("count", COUNT, q.size());
      check_eq("almost_full", ALMOST_FULL, m_af);
      check_eq("overflow", OVERFLOW, m_ov);
      pop  = (q.size() != 0) && rdy;
      free = int'(DEPTH) - q.size() + (pop ? 1 : 0);
      if (pop) void'(q.pop_front());
      if (!(byp && rdy)) begin
         if (en[0]) begin
            if (free > 0) begin q.push_back({t0, d0}); free--; end
            else m_ov = 1;
         end
         if (en[1]) begin
            if (free > 0) begin q.push_back({t1, d1}); free--; end
            else m_ov = 1;
         end
      end
      m_af = (int'(DEPTH) - q.size()) < int'(AF_MARGIN);
   endtask

   task automatic idle(input logic rdy);
      cycle(2'b00, 32'h0, 32'h0, '0, '0, rdy);
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      RST = 1'b1;
      PHASE_EN = 2'b11;
      #1;
      check_eq("rst_wb_valid", WB_VALID, 0);
      check_eq("rst_count", COUNT, 0);
      check_eq("rst_wb_data", WB_DATA, 0);
      check_eq("rst_wb_addr", WB_ADDR, 0);
      check_eq("rst_almost_full", ALMOST_FULL, 0);
      check_eq("rst_overflow", OVERFLOW, 0);
      q.delete();
      m_ov = 0;
      m_af = 0;
      @(negedge CLK);
      PHASE_EN = 2'b00;
      RST = 1'b0;
   endtask

   initial begin
      #12;
      apply_reset();

      // Single push, one-cycle latency, then drained
      cycle(2'b01, 32'h11223344, 32'h0, 6'd5, 6'd0, 1'b1);
      idle(1'b1);
      check_eq("req032_valid", WB_VALID, 1);
      check_eq("req032_data", WB_DATA, 32'h11223344);
      check_eq("req032_addr", WB_ADDR, 5);
      idle(1'b1);
      check_eq("req032_count", COUNT, 0);

      // Dual push: phase 0 written back before phase 1
      cycle(2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 6'd1, 6'd2, 1'b1);
      idle(1'b1);
      check_eq("req033_first_addr", WB_ADDR, 1);
      check_eq("req033_first_data", WB_DATA, 32'hAAAA_0001);
      idle(1'b1);
      check_eq("req033_second_addr", WB_ADDR, 2);
      check_eq("req033_second_data", WB_DATA, 32'hBBBB_0002);
      idle(1'b1);
      check_eq("req033_count", COUNT, 0);

      // Fill with stalled write-back, then overflow
      apply_reset();
      for (int i = 0; i < 4; i++)
         cycle(2'b11, 32'h100 + i, 32'h200 + i, AW'(i), AW'(i + 8), 1'b0);
      idle(1'b0);
      check_eq("req034_count", COUNT, 8);
      check_eq("req034_af", ALMOST_FULL, 1);
      check_eq("req034_ov", OVERFLOW, 0);
      cycle(2'b11, 32'hDEAD, 32'hBEEF, 6'd3, 6'd4, 1'b0);
      idle(1'b0);
      check_eq("req034_ov_set", OVERFLOW, 1);
      check_eq("req034_count_held", COUNT, 8);
      check_eq("req034_head", WB_DATA, 32'h100);
      for (int i = 0; i < 10; i++) idle(1'b1);
      check_eq("req034_ov_sticky", OVERFLOW, 1);

      // Seven stored, pop frees a slot for the second phase
      apply_reset();
      for (int i = 0; i < 3; i++)
         cycle(2'b11, 32'h300 + i, 32'h400 + i, AW'(i), AW'(i + 16), 1'b0);
      cycle(2'b01, 32'h500, 32'h0, 6'd7, 6'd0, 1'b0);
      cycle(2'b11, 32'h600, 32'h601, 6'd9, 6'd10, 1'b1);
      idle(1'b0);
      check_eq("req035_count", COUNT, 8);
      check_eq("req035_ov", OVERFLOW, 0);
      for (int i = 0; i < 10; i++) idle(1'b1);

`ifdef MTSP_ALU_COLLECT_BYPASS_EN
      apply_reset();
      cycle(2'b10, 32'h0, 32'hCAFE0001, 6'd0, 6'd3, 1'b1);
      check_eq("req037_valid", WB_VALID, 1);
      check_eq("req037_data", WB_DATA, 32'hCAFE0001);
      idle(1'b1);
      check_eq("req037_count", COUNT, 0);
`endif

      // Random traffic across pointer wrap, with a reset in the middle
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         logic rdy;
         if (i == 200) apply_reset();
         rdy = ($urandom % 4) < ((i % 100) < 50 ? 1 : 3);
         cycle(2'($urandom_range(0, 3)), $urandom, $urandom,
               AW'($urandom), AW'($urandom), rdy);
      end
      for (int i = 0; i < 12; i++) idle(1'b1);
      check_eq("drain_count", COUNT, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
